// File: rtl/uart_tx_sched_if.sv
// Byte-source and baud-config handshake between the two TX sources and the scheduler.
interface uart_tx_sched_if #(
    parameter int DATA_BITS = 8
);
    logic [1:0]           req;
    logic [DATA_BITS-1:0] data0;
    logic [DATA_BITS-1:0] data1;
    logic [1:0]           gnt;
    logic                 cfg_valid;
    logic [1:0]           cfg_baud;
    logic                 cfg_ack;

    modport master (
        output req, data0, data1, cfg_valid, cfg_baud,
        input  gnt, cfg_ack
    );

    modport slave (
        input  req, data0, data1, cfg_valid, cfg_baud,
        output gnt, cfg_ack
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin two-source UART transmitter: 8N1 framing on oversampled baud ticks,
// baud_rate select updated only between frames.
module uart_tx_sched #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              baud_clk,
    uart_tx_sched_if.slave    bus,
    output logic [1:0]        baud_rate,
    output logic              tx,
    output logic              busy,
    output logic              owner,
    output logic              done
);
    localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic                 baud_q;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 rr_q, rr_d;
    logic                 owner_q, owner_d;
    logic [1:0]           gnt_q, gnt_d;
    logic                 cfg_ack_q, cfg_ack_d;
    logic                 done_q, done_d;
    logic [1:0]           baud_rate_q, baud_rate_d;

    logic tick, os_wrap, win;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        os_cnt_d    = os_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        baud_rate_d = baud_rate_q;
        gnt_d       = 2'b00;
        cfg_ack_d   = 1'b0;
        done_d      = 1'b0;

        tick    = baud_clk & ~baud_q;
        os_wrap = tick && (os_cnt_q == OS_W'(OVERSAMPLE - 1));
        // rr_q only breaks ties; a lone requester always wins
        win     = (bus.req == 2'b11) ? rr_q : bus.req[1];

        if (state_q != IDLE && tick)
            os_cnt_d = os_wrap ? '0 : os_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    baud_rate_d = bus.cfg_baud;
                    cfg_ack_d   = 1'b1;
                end else if (|bus.req) begin
                    shift_d   = win ? bus.data1 : bus.data0;
                    gnt_d     = win ? 2'b10 : 2'b01;
                    owner_d   = win;
                    rr_d      = ~win;
                    os_cnt_d  = '0;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (os_wrap) state_d = DATA;
            end
            DATA: begin
                if (os_wrap) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (os_wrap) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            baud_q      <= 1'b0;
            shift_q     <= '0;
            os_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            rr_q        <= 1'b0;
            owner_q     <= 1'b0;
            gnt_q       <= 2'b00;
            cfg_ack_q   <= 1'b0;
            done_q      <= 1'b0;
            baud_rate_q <= 2'b10;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_clk;
            shift_q     <= shift_d;
            os_cnt_q    <= os_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            cfg_ack_q   <= cfg_ack_d;
            done_q      <= done_d;
            baud_rate_q <= baud_rate_d;
        end
    end

    // tx decoded from state so it drops on the grant edge and idles high in reset
    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
            default: tx = 1'b1;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign owner       = owner_q;
    assign done        = done_q;
    assign baud_rate   = baud_rate_q;
    assign bus.gnt     = gnt_q;
    assign bus.cfg_ack = cfg_ack_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: per-cycle reference model with a frame scoreboard,
// a vector table of transactions, and hand-written multi-cycle sequences.
module tb_uart_tx_sched;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       baud_clk = 1'b0;
    logic [1:0] baud_rate;
    logic       tx, busy, owner, done;

    uart_tx_sched_if #(.DATA_BITS(8)) bus();

    uart_tx_sched #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .baud_clk(baud_clk), .bus(bus),
        .baud_rate(baud_rate), .tx(tx), .busy(busy), .owner(owner), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic       m_idle = 1'b1, m_rr = 1'b0, m_owner = 1'b0, win;
    logic [1:0] m_baud = 2'b10;
    logic       in_frame = 1'b0;
    int         tcnt = 0;
    int         cyc = 0;
    logic [9:0] fbits;
    logic [8:0] sb_q[$];
    logic [8:0] sb_item;
    logic [1:0] req_p = 2'b00, cfgb_p = 2'b00, exp_gnt;
    logic [7:0] d0_p = 8'h00, d1_p = 8'h00;
    logic       cfg_p = 1'b0, exp_ack, exp_done, tick;
    logic       b_last = 1'b0, b_before = 1'b0;
    int         bcnt = 0, bk = 0;

    always @(negedge clk) begin
        cyc++;
        b_before = b_last;
        b_last   = reset ? baud_clk : 1'b0;
        if (!reset) begin
            m_idle = 1'b1; m_rr = 1'b0; m_owner = 1'b0; m_baud = 2'b10;
            in_frame = 1'b0; sb_q.delete();
            chk("rst_tx", tx, 1'b1);
            chk("rst_busy", busy, 1'b0);
            chk("rst_gnt", bus.gnt, 2'b00);
            chk("rst_ack", bus.cfg_ack, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_baud", baud_rate, 2'b10);
            chk("rst_owner", owner, 1'b0);
        end else begin
            tick = b_last & ~b_before;
            exp_gnt = 2'b00; exp_ack = 1'b0; exp_done = 1'b0;
            if (m_idle) begin
                if (cfg_p) begin
                    exp_ack = 1'b1;
                    m_baud  = cfgb_p;
                end else if (req_p != 2'b00) begin
                    win = (req_p == 2'b11) ? m_rr : req_p[1];
                    exp_gnt = win ? 2'b10 : 2'b01;
                    m_rr = ~win; m_owner = win; m_idle = 1'b0;
                    sb_q.push_back({win, win ? d1_p : d0_p});
                    in_frame = 1'b1; tcnt = 0;
                end
            end else if (in_frame && tick) begin
                tcnt++;
                if (tcnt % 16 == 8) fbits[tcnt/16] = tx;
                if (tcnt == 160) begin
                    exp_done = 1'b1; in_frame = 1'b0; m_idle = 1'b1;
                    chk("frame_start_bit", fbits[0], 1'b0);
                    chk("frame_stop_bit", fbits[9], 1'b1);
                    if (sb_q.size() == 0) begin
                        chk("sb_empty", 1, 0);
                    end else begin
                        sb_item = sb_q.pop_front();
                        chk("frame_data", fbits[8:1], sb_item[7:0]);
                        chk("frame_src", owner, sb_item[8]);
                    end
                end
            end
            chk("gnt", bus.gnt, exp_gnt);
            chk("cfg_ack", bus.cfg_ack, exp_ack);
            chk("done", done, exp_done);
            chk("baud_rate", baud_rate, m_baud);
            chk("owner", owner, m_owner);
            chk("busy", busy, !m_idle);
            if (m_idle)              chk("tx_idle", tx, 1'b1);
            else if (exp_gnt != 0)   chk("tx_start_edge", tx, 1'b0);
        end
        req_p = bus.req; d0_p = bus.data0; d1_p = bus.data1;
        cfg_p = bus.cfg_valid; cfgb_p = bus.cfg_baud;
        // irregular baud_clk: high 1..5 clk, low 1..3 clk, so level-vs-edge bugs show
        bcnt--;
        if (bcnt <= 0) begin
            baud_clk = ~baud_clk;
            bk++;
            bcnt = baud_clk ? 1 + (bk % 5) : 1 + (bk % 3);
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [1:0] req;
        logic [7:0] d0, d1;
        logic       cfg_v;
        logic [1:0] cfg_b;
        logic [1:0] exp_gnt;
        logic [1:0] exp_baud;
    } vec_t;
    vec_t tbl[7];

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 4000) begin step(); n++; end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_gnt(output logic [1:0] g);
        int n = 0;
        g = 2'b00;
        while (n < 20) begin
            step(); n++;
            if (bus.gnt != 2'b00) begin g = bus.gnt; return; end
        end
        chk("gnt_timeout", 1, 0);
    endtask

    task automatic wait_tcnt(input int t);
        int n = 0;
        while (tcnt < t && n < 4000) begin step(); n++; end
        if (tcnt < t) chk("tcnt_timeout", tcnt, t);
    endtask

    initial begin
        logic [1:0] g;
        logic       got;
        int         ack_c, last_done, ngnt, c;

        bus.req = 2'b00; bus.data0 = 8'h00; bus.data1 = 8'h00;
        bus.cfg_valid = 1'b0; bus.cfg_baud = 2'b00;

        //            req    d0     d1     cfg_v cfg_b  exp_gnt exp_baud
        tbl[0] = '{2'b01, 8'hA5, 8'h00, 1'b0, 2'b00, 2'b01, 2'b10};
        tbl[1] = '{2'b11, 8'h11, 8'h22, 1'b0, 2'b00, 2'b10, 2'b10};
        tbl[2] = '{2'b11, 8'h11, 8'h22, 1'b0, 2'b00, 2'b01, 2'b10};
        tbl[3] = '{2'b10, 8'h00, 8'h3C, 1'b1, 2'b00, 2'b10, 2'b00};
        tbl[4] = '{2'b10, 8'h00, 8'hC3, 1'b0, 2'b00, 2'b10, 2'b00};
        tbl[5] = '{2'b01, 8'hFF, 8'h00, 1'b0, 2'b00, 2'b01, 2'b00};
        tbl[6] = '{2'b11, 8'h00, 8'h81, 1'b0, 2'b00, 2'b10, 2'b00};

        repeat (3) @(posedge clk);
        @(negedge clk); #1 reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            wait_idle();
            step();
            bus.req = tbl[i].req; bus.data0 = tbl[i].d0; bus.data1 = tbl[i].d1;
            bus.cfg_valid = tbl[i].cfg_v; bus.cfg_baud = tbl[i].cfg_b;
            got = 1'b0; ack_c = -1;
            for (int k = 0; k < 6 && !got; k++) begin
                step();
                if (bus.cfg_ack) begin bus.cfg_valid = 1'b0; ack_c = k; end
                if (bus.gnt != 2'b00) begin
                    got = 1'b1;
                    chk($sformatf("vec%0d_gnt", i), bus.gnt, tbl[i].exp_gnt);
                    chk($sformatf("vec%0d_baud", i), baud_rate, tbl[i].exp_baud);
                    if (tbl[i].cfg_v) chk($sformatf("vec%0d_ack_before_gnt", i), k - ack_c, 1);
                    bus.req = 2'b00;
                end
            end
            if (!got) chk($sformatf("vec%0d_no_gnt", i), 0, 1);
            wait_idle();
        end

        // back-to-back round robin with both sources held
        bus.data0 = 8'h11; bus.data1 = 8'h22; bus.req = 2'b11;
        ngnt = 0; last_done = -100; c = 0;
        while (ngnt < 4 && c < 5000) begin
            step(); c++;
            if (bus.gnt != 2'b00) begin
                chk($sformatf("rr_order%0d", ngnt), bus.gnt, (ngnt % 2 == 0) ? 2'b01 : 2'b10);
                if (ngnt > 0) chk($sformatf("rr_gap%0d", ngnt), c - last_done, 1);
                ngnt++;
                if (ngnt == 4) bus.req = 2'b00;
            end
            if (done) last_done = c;
        end
        if (ngnt < 4) chk("rr_timeout", ngnt, 4);
        wait_idle();

        // config request raised mid-frame waits for the frame to finish
        bus.data0 = 8'h5A; bus.req = 2'b01;
        wait_gnt(g);
        bus.req = 2'b00;
        wait_tcnt(40);
        bus.cfg_valid = 1'b1; bus.cfg_baud = 2'b11;
        got = 1'b0; last_done = -100; c = 0;
        while (!got && c < 4000) begin
            step(); c++;
            if (done) last_done = c;
            if (bus.cfg_ack) begin
                got = 1'b1;
                chk("midcfg_ack_gap", c - last_done, 1);
                chk("midcfg_baud", baud_rate, 2'b11);
                bus.cfg_valid = 1'b0;
            end
        end
        if (!got) chk("midcfg_timeout", 0, 1);
        wait_idle();

        // reset during data bit 3, with rr pointing at source 1
        bus.data0 = 8'h96; bus.req = 2'b01;
        wait_gnt(g);
        bus.req = 2'b00;
        wait_tcnt(70);
        reset = 1'b0;
        #1;
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_baud", baud_rate, 2'b10);
        chk("midrst_done", done, 1'b0);
        bus.data0 = 8'h77; bus.data1 = 8'h88; bus.req = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk); #1 reset = 1'b1;
        wait_gnt(g);
        chk("postrst_first_gnt", g, 2'b01);
        bus.req = 2'b00;
        wait_idle();
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
